// File: rtl/seq_alu_pkg.sv
// Shared op-code table, FSM state encoding and decode helpers for seq_alu.
package seq_alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Iterative ops occupy the 11xx quadrant of the op-code space.
  function automatic logic is_iterative(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// WIDTH-cycle shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               run;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               hi;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;

  // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      if (diff[WIDTH])
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  assign done   = run && (cnt == '0);
  assign result = hi ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      hi     <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CNT_W'(WIDTH - 1);
      is_div <= mode[1];
      hi     <= mode[0];
      opnd   <= mode[1] ? b : a;
      acc    <= {{WIDTH{1'b0}}, (mode[1] ? a : b)};
    end else if (run) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
      if (cnt == '0)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU behind valid/ready handshakes; single-cycle ops plus iterative mul/div.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state, state_next;
  logic               accept;
  logic               iter;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_illegal;
  logic [SHAMT_W-1:0] shamt;
  logic               md_done;
  logic [WIDTH-1:0]   md_result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign iter      = is_iterative(ALUControl);
  assign shamt     = b[SHAMT_W-1:0];

  always_comb begin
    alu_y       = '0;
    alu_illegal = 1'b0;
    case (ALUControl)
      ALU_AND:  alu_y = a & b;
      ALU_OR:   alu_y = a | b;
      ALU_ADD:  alu_y = a + b;
      ALU_XOR:  alu_y = a ^ b;
      ALU_SUB:  alu_y = a - b;
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_y = a << shamt;
      ALU_SRL:  alu_y = a >> shamt;
      ALU_SRA:  alu_y = $signed(a) >>> shamt;
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: alu_y = '0;
      default:  alu_illegal = 1'b1;
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && iter),
    .mode   (ALUControl[1:0]),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = iter ? BUSY : DONE;
      BUSY:    if (md_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else if (accept && !iter) begin
      result  <= alu_y;
      zero    <= (alu_y == '0);
      illegal <= alu_illegal;
    end else if (state == BUSY && md_done) begin
      result  <= md_result;
      zero    <= (md_result == '0);
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32 main instance, WIDTH=8 secondary).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  logic        in_valid8;
  logic        in_ready8;
  logic [3:0]  ALUControl8;
  logic [7:0]  a8, b8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic        zero8;
  logic        illegal8;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUControl(ALUControl8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .zero(zero8), .illegal(illegal8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, capture outputs, then retire it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z, output logic il, output int lat);
    @(negedge clk);
    check("in_ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1; ALUControl = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; il = illegal;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez,
                          input logic eil, input int elat);
    logic [31:0] r;
    logic        z, il;
    int          lat;
    run_op(op, x, y, r, z, il, lat);
    check({tag, "_result"},  64'(r),   64'(er));
    check({tag, "_zero"},    64'(z),   64'(ez));
    check({tag, "_illegal"}, 64'(il),  64'(eil));
    check({tag, "_latency"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    int stale;
    reset = 1'b1; in_valid = 1'b0; ALUControl = '0; a = '0; b = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; ALUControl8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_illegal",   64'(illegal),   64'd0);
    @(negedge clk); reset = 1'b0;

    // Reset mid-DIVU aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'b1110; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("divu_busy_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk); reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("abort_no_stale_output", 64'(stale), 64'd0);
    op_check("add_3_4", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);

    // Single-cycle class.
    op_check("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, 1);
    op_check("sub",      4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    op_check("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    op_check("sltu",     4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    op_check("sra",      4'b1011, 32'h8000_0000, 32'd35, 32'hF000_0000, 1'b0, 1'b0, 1);
    op_check("srl",      4'b1010, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1);
    op_check("sll",      4'b1001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1);
    op_check("and",      4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1);
    op_check("or",       4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0, 1);
    op_check("xor",      4'b0011, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1'b0, 1);

    // Iterative class: latency WIDTH+1.
    op_check("mul_ovf",  4'b1100, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 33);
    op_check("mulhu",    4'b1101, 32'h0001_0000, 32'h0001_0000, 32'h1, 1'b0, 1'b0, 33);
    op_check("mul",      4'b1100, 32'd1234, 32'd5678, 32'h006A_E9BC, 1'b0, 1'b0, 33);
    op_check("divu",     4'b1110, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    op_check("remu",     4'b1111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
    op_check("divu_z",   4'b1110, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    op_check("remu_z",   4'b1111, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 33);

    // Illegal codes.
    op_check("ill_4", 4'b0100, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1, 1);
    op_check("ill_5", 4'b0101, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1, 1);

    // Backpressure: result held while out_ready low; new request not accepted.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'b0010; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd5;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result",    64'(result),    64'd2);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready",  64'(in_ready),  64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("bp_second_not_taken", 64'(out_valid), 64'd0);

    // WIDTH=8 instance: ADD wrap.
    @(negedge clk);
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1; ALUControl8 = 4'b0010; a8 = 8'hFF; b8 = 8'h01;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_out_valid", 64'(out_valid8), 64'd1);
    check("w8_result",    64'(result8),    64'd0);
    check("w8_zero",      64'(zero8),      64'd1);
    check("w8_illegal",   64'(illegal8),   64'd0);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    check("w8_idle", 64'(in_ready8), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
